// File: rtl/mem_mac_engine.sv
// mem_mac_engine: sequential multiply-accumulate engine sharing one BRAM port.
// Reads A[i] and B[i] from one block, accumulates the unsigned products into a
// 32-bit register, then writes the result back as two 16-bit words.
// Yields the memory port while `active` is high.
// Optional build macro MAC_SATURATE_EN: the accumulator clamps to 32'hFFFF_FFFF
// on overflow instead of wrapping modulo 2^32.
module mem_mac_engine #(
  parameter int         MEM_SELECT_BITS = 4,
  parameter int         VEC_LEN         = 8,
  parameter int         BLOCK           = 1,
  parameter logic [7:0] A_BASE          = 8'h00,
  parameter logic [7:0] B_BASE          = 8'h10,
  parameter logic [7:0] RES_ADDR        = 8'h20
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       active,
  input  logic [15:0]                mem_data_out,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [7:0]                 rd_addr,
  output logic [7:0]                 wr_addr,
  output logic [15:0]                data_in,
  output logic                       rd_en,
  output logic                       wr_en,
  output logic                       bram_or_spram,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                acc_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_LAT_A, S_RD_B, S_LAT_B, S_MAC, S_WR_LO, S_WR_HI, S_DONE
  } state_e;

  // Index of the final element; VEC_LEN <= 128 keeps it within 8 bits.
  localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [31:0] mac_prod;
  logic [31:0] mac_next;

  assign mac_prod = 32'(op_a_q) * 32'(op_b_q);

`ifdef MAC_SATURATE_EN
  // A carry out of the 33-bit sum clamps to all ones; a saturated accumulator
  // stays saturated because any further non-zero addend carries again.
  logic [32:0] mac_sum;
  assign mac_sum  = {1'b0, acc_q} + {1'b0, mac_prod};
  assign mac_next = mac_sum[32] ? 32'hFFFF_FFFF : mac_sum[31:0];
`else
  // Plain modulo-2^32 accumulation.
  assign mac_next = acc_q + mac_prod;
`endif

  // Fixed memory routing and result visibility.
  assign mem_select    = MEM_SELECT_BITS'(BLOCK);
  assign bram_or_spram = 1'b0;
  assign acc_out       = acc_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // Next-state, datapath updates and memory strobes (strobes gated by active).
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    data_in = '0;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Accepted even while active; the stall then happens in RD_A.
        if (start) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        rd_addr = A_BASE + idx_q;
        rd_en   = !active;
        if (!active) state_d = S_LAT_A;
      end
      S_LAT_A: begin
        // Data under a stall may belong to the UART side: drop it and reread.
        if (active) begin
          state_d = S_RD_A;
        end else begin
          op_a_d  = mem_data_out;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        rd_addr = B_BASE + idx_q;
        rd_en   = !active;
        if (!active) state_d = S_LAT_B;
      end
      S_LAT_B: begin
        if (active) begin
          state_d = S_RD_B;
        end else begin
          op_b_d  = mem_data_out;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d   = mac_next;
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == LAST_IDX) ? S_WR_LO : S_RD_A;
      end
      S_WR_LO: begin
        wr_addr = RES_ADDR;
        data_in = acc_q[15:0];
        wr_en   = !active;
        if (!active) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        wr_addr = RES_ADDR + 8'd1;
        data_in = acc_q[31:16];
        wr_en   = !active;
        if (!active) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_mac_engine.sv
// Testbench for mem_mac_engine: behavioural BRAM model, scoreboard of expected
// results queued at start and compared when done pulses.
module tb_mem_mac_engine;

  localparam int         N        = 4;
  localparam logic [7:0] A_BASE   = 8'h00;
  localparam logic [7:0] B_BASE   = 8'h10;
  localparam logic [7:0] RES_ADDR = 8'h20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        active = 1'b0;
  logic [15:0] mem_data_out;
  logic [3:0]  mem_select;
  logic [7:0]  rd_addr, wr_addr;
  logic [15:0] data_in;
  logic        rd_en, wr_en, bram_or_spram, busy, done;
  logic [31:0] acc_out;

  mem_mac_engine #(
    .MEM_SELECT_BITS(4), .VEC_LEN(N), .BLOCK(1),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .RES_ADDR(RES_ADDR)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .active(active),
    .mem_data_out(mem_data_out), .mem_select(mem_select),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .data_in(data_in),
    .rd_en(rd_en), .wr_en(wr_en), .bram_or_spram(bram_or_spram),
    .busy(busy), .done(done), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Block-1 memory model: read data valid one cycle after rd_en.
  logic [15:0] mem [0:255];
  int wr_lo_cnt, wr_hi_cnt, rd_b2_cnt, viol_cnt, done_cnt, busy_done_cnt;

  always @(posedge clk) begin
    if (rd_en && mem_select == 4'd1) begin
      mem_data_out <= mem[rd_addr];
      if (rd_addr == B_BASE + 8'd2) rd_b2_cnt++;
    end
    if (wr_en && mem_select == 4'd1) begin
      mem[wr_addr] = data_in;
      if (wr_addr == RES_ADDR)        wr_lo_cnt++;
      if (wr_addr == RES_ADDR + 8'd1) wr_hi_cnt++;
    end
  end

  // Mid-cycle observation of strobes under stall and of the done pulse.
  always @(negedge clk) begin
    if (resetn) begin
      if (active && (rd_en || wr_en)) viol_cnt++;
      if (done) begin
        done_cnt++;
        if (busy) busy_done_cnt++;
      end
    end
  end

  logic [15:0] va [N];
  logic [15:0] vb [N];

  function automatic logic [31:0] model_acc();
    logic [32:0] s;
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      s = {1'b0, r} + ({17'd0, va[j]} * {17'd0, vb[j]});
`ifdef MAC_SATURATE_EN
      r = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
      r = s[31:0];
`endif
    end
    return r;
  endfunction

  task automatic load_vectors();
    for (int j = 0; j < N; j++) begin
      mem[A_BASE + 8'(j)] = va[j];
      mem[B_BASE + 8'(j)] = vb[j];
    end
    mem[RES_ADDR]        = 16'hDEAD;
    mem[RES_ADDR + 8'd1] = 16'hBEEF;
  endtask

  typedef struct {
    logic [31:0] acc;
    int          lat;
    int          b2_reads;
  } exp_t;

  exp_t sb_q[$];

  // One run. Called right after posedge+#1 with the engine idle.
  // lat: count of edges after the start-sampling edge until the edge that
  // enters DONE (done is then sampled high on the following edge).
  task automatic run(input string name, input int act_from, input int act_len,
                     input bit restart, input int extra_lat, input int b2_reads);
    exp_t e;
    exp_t got;
    bit   seen;
    int   lat_obs;
    e.acc      = model_acc();
    e.lat      = 5 * N + 2 + extra_lat;
    e.b2_reads = b2_reads;
    sb_q.push_back(e);
    wr_lo_cnt = 0; wr_hi_cnt = 0; rd_b2_cnt = 0;
    viol_cnt = 0; done_cnt = 0; busy_done_cnt = 0;
    start  = 1'b1;
    active = (act_len > 0 && act_from == 0);
    seen    = 1'b0;
    lat_obs = -1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk); #1;
      start  = restart && (k == 10 || k == e.lat);
      active = (act_len > 0 && k >= act_from && k < act_from + act_len);
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        lat_obs = k;
      end
    end
    // Tail: the first edge here samples any start raised in the DONE cycle.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      active = 1'b0;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check({name, " acc_out"},  acc_out, got.acc);
      check({name, " res_lo"},   32'(mem[RES_ADDR]), 32'(got.acc[15:0]));
      check({name, " res_hi"},   32'(mem[RES_ADDR + 8'd1]), 32'(got.acc[31:16]));
      check({name, " latency"},  32'(lat_obs), 32'(got.lat));
      check({name, " b2_reads"}, 32'(rd_b2_cnt), 32'(got.b2_reads));
    end
    check({name, " wr_lo_cnt"}, 32'(wr_lo_cnt), 32'd1);
    check({name, " wr_hi_cnt"}, 32'(wr_hi_cnt), 32'd1);
    check({name, " done_cnt"},  32'(done_cnt), 32'd1);
    check({name, " stall_strobes"}, 32'(viol_cnt), 32'd0);
    check({name, " busy_in_done"},  32'(busy_done_cnt), 32'd0);
    check({name, " idle_after"},    32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " busy"},    32'(busy), 32'd0);
    check({name, " done"},    32'(done), 32'd0);
    check({name, " rd_en"},   32'(rd_en), 32'd0);
    check({name, " wr_en"},   32'(wr_en), 32'd0);
    check({name, " acc_out"}, acc_out, 32'd0);
    check({name, " rd_addr"}, 32'(rd_addr), 32'd0);
    check({name, " wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, " data_in"}, 32'(data_in), 32'd0);
  endtask

  initial begin
    for (int j = 0; j < 256; j++) mem[j] = 16'h0000;
    #1;
    check_reset_values("reset");
    check("mem_select", 32'(mem_select), 32'd1);
    check("bram_or_spram", 32'(bram_or_spram), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;

    // 1: small dot product, 1*5+2*6+3*7+4*8 = 70.
    va = '{16'd1, 16'd2, 16'd3, 16'd4};
    vb = '{16'd5, 16'd6, 16'd7, 16'd8};
    load_vectors();
    run("t1", 0, 0, 1'b0, 0, 1);
    check("t1 acc_const", acc_out, 32'd70);

    // 2: all ones, wraps (or saturates) the accumulator.
    for (int j = 0; j < N; j++) begin va[j] = 16'hFFFF; vb[j] = 16'hFFFF; end
    load_vectors();
    run("t2", 0, 0, 1'b0, 0, 1);
`ifdef MAC_SATURATE_EN
    check("t2 acc_const", acc_out, 32'hFFFF_FFFF);
`else
    check("t2 acc_const", acc_out, 32'hFFF8_0004);
`endif

    // 3: stall 3 cycles starting in LAT_B of element 2 (after edge 13):
    // B[2] is reread and done slips by 4 cycles.
    va = '{16'd1, 16'd2, 16'd3, 16'd4};
    vb = '{16'd5, 16'd6, 16'd7, 16'd8};
    load_vectors();
    run("t3", 13, 3, 1'b0, 4, 2);

    // 4: start pulsed mid-run and in the DONE cycle.
    load_vectors();
    run("t4", 0, 0, 1'b1, 0, 1);

    // 5: reset asserted in the MAC cycle of element 3 (after edge 19).
    load_vectors();
    mem[RES_ADDR]        = 16'hA5A5;
    mem[RES_ADDR + 8'd1] = 16'h5A5A;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check_reset_values("t5 mid_reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("t5 res_lo_kept", 32'(mem[RES_ADDR]), 32'h0000_A5A5);
    check("t5 res_hi_kept", 32'(mem[RES_ADDR + 8'd1]), 32'h0000_5A5A);
    run("t5 rerun", 0, 0, 1'b0, 0, 1);

    // 6: active high at start, released after 10 cycles.
    load_vectors();
    run("t6", 0, 10, 1'b0, 10, 1);

    // Random operand runs.
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < N; j++) begin
        va[j] = 16'($urandom);
        vb[j] = 16'($urandom);
      end
      load_vectors();
      run("rand", 0, 0, 1'b0, 0, 1);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
